bf_run_sequencer: RTL and testbench

//  Boot/run controller for one brainfuckCore. Loads a program byte stream into code RAM,

---
 rtl/bf_run_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_bf_run_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_run_sequencer.sv
`default_nettype none
//==============================================================================
// Module  : bf_run_sequencer
// Brief   : Boot/run controller for one brainfuck core. Streams a program into
//           code RAM, appends a 0x00 terminator, zeroes the array RAM, releases
//           the core and detects halt. Owns the array-RAM port mux.
//           Define BF_CYCLE_COUNT_EN to add the run_cycles counter output.
// Revision: 1.0 - initial release
//==============================================================================
module bf_run_sequencer #(
    parameter int ADDR_SIZE = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 load_valid,
    input  logic [7:0]           load_data,
    input  logic                 load_last,
    output logic                 load_ready,
    output logic                 code_we,
    output logic [ADDR_SIZE-1:0] code_addr,
    output logic [7:0]           code_wdata,
    output logic                 core_reset,
    input  logic [1:0]           core_state,
    input  logic [ADDR_SIZE-1:0] core_addr_array,
    input  logic [7:0]           core_dout_array,
    input  logic                 core_we_array,
    input  logic [ADDR_SIZE-1:0] dbg_addr,
    output logic [ADDR_SIZE-1:0] arr_addr,
    output logic [7:0]           arr_wdata,
    output logic                 arr_we,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
`ifdef BF_CYCLE_COUNT_EN
    ,
    output logic [31:0]          run_cycles
`endif
);

    localparam logic [ADDR_SIZE-1:0] c_addr_max = '1;
    localparam logic [ADDR_SIZE-1:0] c_addr_one = ADDR_SIZE'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PAD   = 3'd2,
        S_CLEAR = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 r_state;
    logic [ADDR_SIZE-1:0]   r_ptr;
    logic [ADDR_SIZE-1:0]   r_clr_addr;
    logic                   r_code_we;
    logic [ADDR_SIZE-1:0]   r_code_addr;
    logic [7:0]             r_code_wdata;
    logic                   r_core_reset;
    logic                   r_overflow;
    logic                   w_accept;
    logic                   w_clear_last;

    // The last code slot is reserved for the terminator, so loading stops one short.
    assign load_ready   = (r_state == S_LOAD) && (r_ptr != c_addr_max);
    assign w_accept     = load_ready && load_valid;
    assign w_clear_last = (r_state == S_CLEAR) && (r_clr_addr == c_addr_max);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_clr_addr   <= '0;
            r_code_we    <= 1'b0;
            r_code_addr  <= '0;
            r_code_wdata <= '0;
            r_core_reset <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_code_we <= 1'b0;
            if (abort) begin
                r_state      <= S_IDLE;
                r_ptr        <= '0;
                r_clr_addr   <= '0;
                r_core_reset <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_state      <= S_LOAD;
                            r_ptr        <= '0;
                            r_overflow   <= 1'b0;
                            r_core_reset <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        if (w_accept) begin
                            r_code_we    <= 1'b1;
                            r_code_addr  <= r_ptr;
                            r_code_wdata <= load_data;
                            r_ptr        <= r_ptr + c_addr_one;
                            if (load_last) begin
                                r_state <= S_PAD;
                            end
                        end else if (r_ptr == c_addr_max) begin
                            r_overflow <= 1'b1;
                            r_state    <= S_PAD;
                        end
                    end
                    S_PAD: begin
                        r_code_we    <= 1'b1;
                        r_code_addr  <= r_ptr;
                        r_code_wdata <= 8'h00;
                        r_clr_addr   <= '0;
                        r_state      <= S_CLEAR;
                    end
                    S_CLEAR: begin
                        if (w_clear_last) begin
                            r_state      <= S_RUN;
                            r_core_reset <= 1'b1;
                        end else begin
                            r_clr_addr <= r_clr_addr + c_addr_one;
                        end
                    end
                    S_RUN: begin
                        if (core_state == 2'd3) begin
                            r_state <= S_DONE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Array RAM owner: sequencer while clearing, core while running, host when done.
    always_comb begin
        arr_addr  = '0;
        arr_wdata = 8'h00;
        arr_we    = 1'b0;
        case (r_state)
            S_CLEAR: begin
                arr_addr = r_clr_addr;
                arr_we   = 1'b1;
            end
            S_RUN: begin
                arr_addr  = core_addr_array;
                arr_wdata = core_dout_array;
                arr_we    = core_we_array;
            end
            S_DONE: begin
                arr_addr = dbg_addr;
            end
            default: begin
                arr_addr = '0;
            end
        endcase
    end

    assign code_we    = r_code_we;
    assign code_addr  = r_code_addr;
    assign code_wdata = r_code_wdata;
    assign core_reset = r_core_reset;
    assign overflow   = r_overflow;
    assign done       = (r_state == S_DONE);
    assign busy       = (r_state == S_LOAD) || (r_state == S_PAD) ||
                        (r_state == S_CLEAR) || (r_state == S_RUN);

`ifdef BF_CYCLE_COUNT_EN
    logic [31:0] r_run_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run_cycles <= '0;
        end else if (abort) begin
            r_run_cycles <= '0;
        end else if (w_clear_last) begin
            r_run_cycles <= '0;
        end else if ((r_state == S_RUN) && (r_run_cycles != 32'hFFFF_FFFF)) begin
            r_run_cycles <= r_run_cycles + 32'd1;
        end
    end

    assign run_cycles = r_run_cycles;
`else
    // No run-cycle counter in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_bf_run_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module  : tb_bf_run_sequencer
// Brief   : Scoreboard bench for bf_run_sequencer with a behavioural core and
//           tape-level reference interpreter.
// Revision: 1.0 - initial release
//==============================================================================
module tb_bf_run_sequencer;

    localparam int ADDR_SIZE = 9;
    localparam int DEPTH     = 1 << ADDR_SIZE;
    localparam int MAX_ACC   = DEPTH - 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic                 load_valid = 1'b0;
    logic [7:0]           load_data = 8'h00;
    logic                 load_last = 1'b0;
    logic                 load_ready;
    logic                 code_we;
    logic [ADDR_SIZE-1:0] code_addr;
    logic [7:0]           code_wdata;
    logic                 core_reset;
    logic [1:0]           core_state;
    logic [ADDR_SIZE-1:0] core_addr_array;
    logic [7:0]           core_dout_array;
    logic                 core_we_array;
    logic [ADDR_SIZE-1:0] dbg_addr = '0;
    logic [ADDR_SIZE-1:0] arr_addr;
    logic [7:0]           arr_wdata;
    logic                 arr_we;
    logic                 busy;
    logic                 done;
    logic                 overflow;
`ifdef BF_CYCLE_COUNT_EN
    logic [31:0]          run_cycles;
`endif

    bf_run_sequencer #(.ADDR_SIZE(ADDR_SIZE)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .load_valid      (load_valid),
        .load_data       (load_data),
        .load_last       (load_last),
        .load_ready      (load_ready),
        .code_we         (code_we),
        .code_addr       (code_addr),
        .code_wdata      (code_wdata),
        .core_reset      (core_reset),
        .core_state      (core_state),
        .core_addr_array (core_addr_array),
        .core_dout_array (core_dout_array),
        .core_we_array   (core_we_array),
        .dbg_addr        (dbg_addr),
        .arr_addr        (arr_addr),
        .arr_wdata       (arr_wdata),
        .arr_we          (arr_we),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow)
`ifdef BF_CYCLE_COUNT_EN
        ,
        .run_cycles      (run_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // RAM models
    logic [7:0] code_mem [DEPTH];
    logic [7:0] arr_mem  [DEPTH];
    always @(posedge clk) begin
        if (code_we) code_mem[code_addr] <= code_wdata;
        if (arr_we)  arr_mem[arr_addr]   <= arr_wdata;
    end

    // Scoreboard queues filled by stimulus, drained by monitor
    logic [16:0]          code_q[$];
    logic [ADDR_SIZE-1:0] clr_q[$];

    always @(negedge clk) begin
        logic [16:0] w;
        if (reset) begin
            if (code_we) begin
                if (code_q.size() == 0) check("code_wr_unexpected", code_we, 0);
                else begin
                    w = code_q.pop_front();
                    check("code_wr_addr", code_addr, w[16:8]);
                    check("code_wr_data", code_wdata, w[7:0]);
                end
            end
            if (arr_we && !core_reset) begin
                if (clr_q.size() == 0) check("clr_wr_unexpected", arr_we, 0);
                else check("clr_wr", {arr_addr, arr_wdata}, {clr_q.pop_front(), 8'h00});
            end
        end
    end

    // Behavioural brainfuck core: one instruction per cycle while released
    int pc, dp, depth;
    logic [7:0] op;
    initial begin
        core_state = 2'd0; core_we_array = 1'b0; core_addr_array = '0; core_dout_array = '0;
        forever begin
            @(posedge clk); #1;
            if (!core_reset) begin
                pc = 0; dp = 0; core_state = 2'd0; core_we_array = 1'b0;
                core_addr_array = '0; core_dout_array = '0;
            end else if (core_state != 2'd3) begin
                op = (pc < DEPTH) ? code_mem[pc] : 8'h00;
                core_we_array = 1'b0;
                core_state = 2'd1;
                case (op)
                    8'h2B: begin core_dout_array = arr_mem[dp] + 8'd1; core_we_array = 1'b1; pc++; end
                    8'h2D: begin core_dout_array = arr_mem[dp] - 8'd1; core_we_array = 1'b1; pc++; end
                    8'h3E: begin dp = (dp + 1) % DEPTH; pc++; end
                    8'h3C: begin dp = (dp + DEPTH - 1) % DEPTH; pc++; end
                    8'h5B: begin
                        if (arr_mem[dp] == 8'h00) begin
                            depth = 1;
                            while (depth != 0 && pc < DEPTH - 1) begin
                                pc++;
                                if (code_mem[pc] == 8'h5B) depth++;
                                else if (code_mem[pc] == 8'h5D) depth--;
                            end
                        end
                        pc++;
                    end
                    8'h5D: begin
                        if (arr_mem[dp] != 8'h00) begin
                            depth = 1;
                            while (depth != 0 && pc > 0) begin
                                pc--;
                                if (code_mem[pc] == 8'h5D) depth++;
                                else if (code_mem[pc] == 8'h5B) depth--;
                            end
                        end
                        pc++;
                    end
                    default: core_state = 2'd3;
                endcase
                core_addr_array = ADDR_SIZE'(dp);
            end
        end
    end

    // Reference: interpret the accepted program on a plain tape
    logic [7:0] exp_tape [DEPTH];
    int exp_steps;

    task automatic ref_run(input logic [7:0] prog[$]);
        int match[$];
        int stack[$];
        int rpc, rdp, j;
        for (int i = 0; i < DEPTH; i++) exp_tape[i] = 8'h00;
        for (int i = 0; i < prog.size(); i++) match.push_back(0);
        for (int i = 0; i < prog.size(); i++) begin
            if (prog[i] == 8'h5B) stack.push_back(i);
            else if (prog[i] == 8'h5D) begin j = stack.pop_back(); match[i] = j; match[j] = i; end
        end
        rpc = 0; rdp = 0; exp_steps = 0;
        while (rpc < prog.size() && exp_steps < 200000) begin
            case (prog[rpc])
                8'h2B: exp_tape[rdp] = exp_tape[rdp] + 8'd1;
                8'h2D: exp_tape[rdp] = exp_tape[rdp] - 8'd1;
                8'h3E: rdp = (rdp + 1) % DEPTH;
                8'h3C: rdp = (rdp + DEPTH - 1) % DEPTH;
                8'h5B: if (exp_tape[rdp] == 8'h00) rpc = match[rpc];
                8'h5D: if (exp_tape[rdp] != 8'h00) rpc = match[rpc];
                default: ;
            endcase
            rpc++;
            exp_steps++;
        end
    endtask

    task automatic prep(input logic [7:0] prog[$], output int n_acc, output bit ovf);
        logic [7:0] acc_prog[$];
        n_acc = (prog.size() > MAX_ACC) ? MAX_ACC : prog.size();
        ovf   = (prog.size() > MAX_ACC);
        for (int i = 0; i < n_acc; i++) begin
            acc_prog.push_back(prog[i]);
            code_q.push_back({ADDR_SIZE'(i), prog[i]});
        end
        code_q.push_back({ADDR_SIZE'(n_acc), 8'h00});
        for (int i = 0; i < DEPTH; i++) clr_q.push_back(ADDR_SIZE'(i));
        ref_run(acc_prog);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic drive_bytes(input logic [7:0] prog[$], output int got);
        bit acc;
        got = 0;
        for (int i = 0; i < prog.size(); i++) begin
            if ($urandom_range(3) == 0) begin
                load_valid = 1'b0;
                @(posedge clk); #1;
            end
            load_valid = 1'b1; load_data = prog[i]; load_last = (i == prog.size() - 1);
            acc = 1'b0;
            for (int w = 0; w < 4 && !acc; w++) begin
                @(negedge clk);
                if (load_ready) acc = 1'b1;
                @(posedge clk); #1;
            end
            if (!acc) break;
            got++;
        end
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic dbg_read(input int a, output logic [7:0] d);
        @(posedge clk); #1 dbg_addr = ADDR_SIZE'(a);
        @(negedge clk);
        d = arr_mem[arr_addr];
    endtask

    task automatic run_program(input logic [7:0] prog[$], input bit poke_start);
        int n_acc, got, bad;
        bit ovf;
        prep(prog, n_acc, ovf);
        pulse_start();
        check("busy_after_start", busy, 1);
        check("ovf_clear_on_start", overflow, 0);
        drive_bytes(prog, got);
        check("bytes_accepted", got, n_acc);
        if (poke_start) pulse_start();
        for (int c = 0; c < 40000 && !done; c++) @(negedge clk);
        check("done_reached", done, 1);
        check("overflow_flag", overflow, ovf);
        check("busy_in_done", busy, 0);
        check("core_reset_in_done", core_reset, 1);
        check("code_q_drained", code_q.size(), 0);
        check("clr_q_drained", clr_q.size(), 0);
`ifdef BF_CYCLE_COUNT_EN
        check("run_cycles", run_cycles, exp_steps + 1);
`endif
        bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            @(posedge clk); #1 dbg_addr = ADDR_SIZE'(a);
            @(negedge clk);
            if (arr_we !== 1'b0 || arr_addr !== ADDR_SIZE'(a) || arr_mem[arr_addr] !== exp_tape[a]) bad++;
        end
        check("tape_bad_cells", bad, 0);
`ifdef BF_CYCLE_COUNT_EN
        check("run_cycles_frozen", run_cycles, exp_steps + 1);
`endif
    endtask

    task automatic gen_random(output logic [7:0] p[$]);
        int len;
        logic [7:0] ops[4];
        ops[0] = 8'h2B; ops[1] = 8'h2D; ops[2] = 8'h3E; ops[3] = 8'h3C;
        p = {};
        len = $urandom_range(30, 1);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(9) == 0) begin
                p.push_back(8'h5B); p.push_back(8'h2D); p.push_back(8'h5D);
            end else begin
                p.push_back(ops[$urandom_range(5) % 4]);
            end
        end
    endtask

    logic [7:0] prog[$];
    logic [7:0] rd;
    int n_acc_m, got_m;
    bit ovf_m;

    initial begin
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {load_ready, code_we, code_addr, code_wdata, core_reset, arr_addr,
                                arr_wdata, arr_we, busy, done, overflow}, 0);
        @(posedge clk); #1 reset = 1'b1;

        // load_valid outside LOAD is ignored
        load_valid = 1'b1; load_data = 8'h2B;
        @(negedge clk);
        check("idle_ready", load_ready, 0);
        check("idle_busy", busy, 0);
        @(posedge clk); #1 load_valid = 1'b0;

        prog = {8'h2B, 8'h2B, 8'h2B};
        run_program(prog, 1'b0);
        dbg_read(0, rd);
        check("plus3_cell0", rd, 8'h03);

        prog = {8'h2B, 8'h5B, 8'h2D, 8'h5D};
        run_program(prog, 1'b1);
        dbg_read(0, rd);
        check("loop_cell0", rd, 8'h00);
        check("loop_overflow", overflow, 0);

        // start and abort together in DONE: abort wins
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        check("startabort_busy", busy, 0);
        check("startabort_done", done, 0);
        check("startabort_ready", load_ready, 0);

        for (int t = 0; t < 6; t++) begin
            gen_random(prog);
            run_program(prog, 1'($urandom_range(1)));
        end

        prog = {};
        for (int i = 0; i < 600; i++) prog.push_back(8'h2B);
        run_program(prog, 1'b0);
        check("ovf_flag_set", overflow, 1);
        dbg_read(0, rd);
        check("ovf_cell0", rd, 8'hFF);

        // abort mid-clear
        gen_random(prog);
        prep(prog, n_acc_m, ovf_m);
        pulse_start();
        drive_bytes(prog, got_m);
        for (int c = 0; c < 3000 && !(arr_we && !core_reset && arr_addr == ADDR_SIZE'(100)); c++)
            @(negedge clk);
        check("clear_reached_100", arr_addr, 100);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("abort_arr_we", arr_we, 0);
        check("abort_core_reset", core_reset, 0);
        check("abort_busy", busy, 0);
        code_q.delete(); clr_q.delete();

        // async reset in the middle of a run
        prog = {};
        for (int i = 0; i < 60; i++) prog.push_back(8'h2B);
        prep(prog, n_acc_m, ovf_m);
        pulse_start();
        drive_bytes(prog, got_m);
        for (int c = 0; c < 3000 && !core_reset; c++) @(negedge clk);
        check("run_entered", core_reset, 1);
        repeat (10) @(posedge clk);
        @(negedge clk); #1 reset = 1'b0;
        #1;
        check("reset_midrun_outputs", {load_ready, code_we, code_addr, code_wdata, core_reset, arr_addr,
                                       arr_wdata, arr_we, busy, done, overflow}, 0);
        code_q.delete(); clr_q.delete();
        @(posedge clk); #1 reset = 1'b1;

        gen_random(prog);
        run_program(prog, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
